// File: rtl/lock_supervisor.sv
// lock_supervisor: three-digit keypad lock with failure lockout and
// an optional code reprogramming path (enabled by `define LOCK_PROGRAM_EN).
//
// Ports:
//   clk       - sole clock, rising edge
//   reset     - synchronous, active-high
//   x         - entered digit, sampled when x_valid=1
//   x_valid   - one-cycle digit strobe
//   clear     - abort the current entry (or programming)
//   prog      - in OPEN, start reprogramming (LOCK_PROGRAM_EN only)
//   y         - unlock, registered
//   alarm     - high throughout lockout, registered
//   fail_cnt  - consecutive failed attempts, registered
//   digit_idx - digits collected in the current entry (0..2)
module lock_supervisor #(
    parameter logic [8:0] CODE           = 9'b011_111_101,
    parameter int         MAX_FAIL       = 3,
    parameter int         OPEN_CYCLES    = 8,
    parameter int         LOCKOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] x,
    input  logic       x_valid,
    input  logic       clear,
    input  logic       prog,
    output logic       y,
    output logic       alarm,
    output logic [3:0] fail_cnt,
    output logic [1:0] digit_idx
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GOT1    = 3'd1,
        GOT2    = 3'd2,
        OPEN    = 3'd3,
`ifdef LOCK_PROGRAM_EN
        LOCKOUT = 3'd4,
        PROG0   = 3'd5,
        PROG1   = 3'd6,
        PROG2   = 3'd7
`else
        LOCKOUT = 3'd4
`endif
    } state_t;

    // Dwell counters are loaded with N-1 so the output stays high
    // for exactly N cycles, the last one being the cycle with count 0.
    localparam logic [15:0] OPEN_LD = 16'(OPEN_CYCLES - 1);
    localparam logic [15:0] LOCK_LD = 16'(LOCKOUT_CYCLES - 1);
    localparam logic [4:0]  MAX_F   = 5'(MAX_FAIL);

    state_t      state_q, state_d;
    logic        mis_q, mis_d;
    logic [3:0]  fail_q, fail_d;
    logic [15:0] cnt_q, cnt_d;
    logic        y_q, y_d;
    logic        alarm_q, alarm_d;
    logic [8:0]  code;

`ifdef LOCK_PROGRAM_EN
    logic [8:0]  code_q, code_d;
    logic [5:0]  pbuf_q, pbuf_d;

    assign code = code_q;
`else
    wire unused_prog = prog;

    assign code = CODE;
`endif

    logic [2:0] exp_digit;
    logic       dig_bad;
    logic       any_bad;
    logic [4:0] fail_inc;

    // Digit position follows the entry state; GOT2 holds the last digit.
    always_comb begin
        exp_digit = code[2:0];
        if (state_q == IDLE) begin
            exp_digit = code[8:6];
        end else if (state_q == GOT1) begin
            exp_digit = code[5:3];
        end
    end

    assign dig_bad  = (x != exp_digit);
    assign any_bad  = mis_q | dig_bad;
    assign fail_inc = {1'b0, fail_q} + 5'd1;

    always_comb begin
        state_d = state_q;
        mis_d   = mis_q;
        fail_d  = fail_q;
        cnt_d   = cnt_q;
        y_d     = 1'b0;
        alarm_d = 1'b0;
`ifdef LOCK_PROGRAM_EN
        code_d  = code_q;
        pbuf_d  = pbuf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    mis_d = 1'b0;
                end else if (x_valid) begin
                    mis_d   = dig_bad;
                    state_d = GOT1;
                end
            end
            GOT1: begin
                if (clear) begin
                    mis_d   = 1'b0;
                    state_d = IDLE;
                end else if (x_valid) begin
                    mis_d   = any_bad;
                    state_d = GOT2;
                end
            end
            GOT2: begin
                if (clear) begin
                    mis_d   = 1'b0;
                    state_d = IDLE;
                end else if (x_valid) begin
                    mis_d = 1'b0;
                    if (!any_bad) begin
                        state_d = OPEN;
                        fail_d  = 4'd0;
                        y_d     = 1'b1;
                        cnt_d   = OPEN_LD;
                    end else if (fail_inc == MAX_F) begin
                        state_d = LOCKOUT;
                        fail_d  = MAX_F[3:0];
                        alarm_d = 1'b1;
                        cnt_d   = LOCK_LD;
                    end else begin
                        state_d = IDLE;
                        fail_d  = fail_inc[3:0];
                    end
                end
            end
            OPEN: begin
                if (cnt_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                    y_d   = 1'b1;
                end
`ifdef LOCK_PROGRAM_EN
                if (prog) begin
                    state_d = PROG0;
                    y_d     = 1'b0;
                    cnt_d   = 16'd0;
                end
`endif
            end
            LOCKOUT: begin
                if (cnt_q == 16'd0) begin
                    state_d = IDLE;
                    fail_d  = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 16'd1;
                    alarm_d = 1'b1;
                end
            end
`ifdef LOCK_PROGRAM_EN
            PROG0: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (x_valid) begin
                    pbuf_d[5:3] = x;
                    state_d     = PROG1;
                end
            end
            PROG1: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (x_valid) begin
                    pbuf_d[2:0] = x;
                    state_d     = PROG2;
                end
            end
            PROG2: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (x_valid) begin
                    // Whole code replaced in one edge.
                    code_d  = {pbuf_q, x};
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mis_q   <= 1'b0;
            fail_q  <= 4'd0;
            cnt_q   <= 16'd0;
            y_q     <= 1'b0;
            alarm_q <= 1'b0;
`ifdef LOCK_PROGRAM_EN
            code_q  <= CODE;
            pbuf_q  <= 6'd0;
`endif
        end else begin
            state_q <= state_d;
            mis_q   <= mis_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            alarm_q <= alarm_d;
`ifdef LOCK_PROGRAM_EN
            code_q  <= code_d;
            pbuf_q  <= pbuf_d;
`endif
        end
    end

    always_comb begin
        digit_idx = 2'd0;
        if (state_q == GOT1) begin
            digit_idx = 2'd1;
        end else if (state_q == GOT2) begin
            digit_idx = 2'd2;
        end
    end

    assign y        = y_q;
    assign alarm    = alarm_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// tb_lock_supervisor: directed scenarios plus random stimulus, every
// cycle compared against a digit-buffer / timer model of the lock.
module tb_lock_supervisor;

    localparam logic [8:0] CODE           = 9'b011_111_101;
    localparam int         MAX_FAIL       = 3;
    localparam int         OPEN_CYCLES    = 8;
    localparam int         LOCKOUT_CYCLES = 32;
`ifdef LOCK_PROGRAM_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [2:0] x;
    logic       x_valid;
    logic       clear;
    logic       prog;
    logic       y;
    logic       alarm;
    logic [3:0] fail_cnt;
    logic [1:0] digit_idx;

    lock_supervisor #(
        .CODE           (CODE),
        .MAX_FAIL       (MAX_FAIL),
        .OPEN_CYCLES    (OPEN_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .x_valid   (x_valid),
        .clear     (clear),
        .prog      (prog),
        .y         (y),
        .alarm     (alarm),
        .fail_cnt  (fail_cnt),
        .digit_idx (digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: digits collected so far, remaining open/lockout time,
    // programming buffer and the current code.
    int         m_en;
    logic [8:0] m_ent;
    int         m_open;
    int         m_lock;
    int         m_fail;
    bit         m_prog;
    int         m_pn;
    logic [8:0] m_pbuf;
    logic [8:0] m_code;

    task automatic model_reset();
        m_en   = 0;
        m_ent  = '0;
        m_open = 0;
        m_lock = 0;
        m_fail = 0;
        m_prog = 1'b0;
        m_pn   = 0;
        m_pbuf = '0;
        m_code = CODE;
    endtask

    task automatic model_step(bit rst, bit xv, logic [2:0] xd,
                              bit clr, bit prg);
        if (rst) begin
            model_reset();
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fail = 0;
        end else if (m_open > 0) begin
            if (PROG_EN && prg) begin
                m_open = 0;
                m_prog = 1'b1;
                m_pn   = 0;
            end else begin
                m_open--;
            end
        end else if (m_prog) begin
            if (clr) begin
                m_prog = 1'b0;
            end else if (xv) begin
                m_pbuf = {m_pbuf[5:0], xd};
                m_pn++;
                if (m_pn == 3) begin
                    m_code = m_pbuf;
                    m_prog = 1'b0;
                end
            end
        end else begin
            if (clr) begin
                m_en = 0;
            end else if (xv) begin
                m_ent = {m_ent[5:0], xd};
                m_en++;
                if (m_en == 3) begin
                    m_en = 0;
                    if (m_ent == m_code) begin
                        m_open = OPEN_CYCLES;
                        m_fail = 0;
                    end else begin
                        m_fail++;
                        if (m_fail == MAX_FAIL) m_lock = LOCKOUT_CYCLES;
                    end
                end
            end
        end
    endtask

    task automatic step(bit rst, bit xv, logic [2:0] xd, bit clr, bit prg);
        int exp_idx;
        reset   = rst;
        x_valid = xv;
        x       = xd;
        clear   = clr;
        prog    = prg;
        @(posedge clk);
        #1;
        model_step(rst, xv, xd, clr, prg);
        exp_idx = (m_open > 0 || m_lock > 0 || m_prog) ? 0 : m_en;
        check("y", {31'd0, y}, (m_open > 0) ? 32'd1 : 32'd0);
        check("alarm", {31'd0, alarm}, (m_lock > 0) ? 32'd1 : 32'd0);
        check("fail_cnt", {28'd0, fail_cnt}, 32'(m_fail));
        check("digit_idx", {30'd0, digit_idx}, 32'(exp_idx));
        reset   = 1'b0;
        x_valid = 1'b0;
        clear   = 1'b0;
        prog    = 1'b0;
    endtask

    task automatic digit(logic [2:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic enter3(logic [2:0] a, logic [2:0] b, logic [2:0] c);
        digit(a);
        digit(b);
        digit(c);
    endtask

    initial begin
        logic [2:0] good [3];
        int         n;
        int         ny;
        bit         r_rst;
        bit         r_xv;
        bit         r_clr;
        bit         r_prg;
        logic [2:0] r_d;
        logic [8:0] sh;

        good[0] = 3'd3;
        good[1] = 3'd7;
        good[2] = 3'd5;
        reset   = 1'b0;
        x       = 3'd0;
        x_valid = 1'b0;
        clear   = 1'b0;
        prog    = 1'b0;
        model_reset();

        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd3, 1'b1, 1'b1);

        // Correct code: open for exactly OPEN_CYCLES.
        digit(3'd3);
        digit(3'd7);
        digit(3'd5);
        n = int'(y);
        for (int i = 0; i < 11; i++) begin
            idle(1);
            n += int'(y);
        end
        check("open_len", 32'(n), 32'(OPEN_CYCLES));
        check("open_fail", {28'd0, fail_cnt}, 32'd0);

        // Three failures, lockout, ignored entry during lockout.
        enter3(3'd3, 3'd7, 3'd4);
        check("fail1", {28'd0, fail_cnt}, 32'd1);
        enter3(3'd0, 3'd0, 3'd0);
        check("fail2", {28'd0, fail_cnt}, 32'd2);
        enter3(3'd1, 3'd1, 3'd1);
        check("fail_sat", {28'd0, fail_cnt}, 32'(MAX_FAIL));
        n  = int'(alarm);
        ny = 0;
        for (int i = 0; i < 40; i++) begin
            if (i < 3) digit(good[i]);
            else idle(1);
            n  += int'(alarm);
            ny += int'(y);
        end
        check("alarm_len", 32'(n), 32'(LOCKOUT_CYCLES));
        check("y_in_lockout", 32'(ny), 32'd0);
        check("fail_after_lock", {28'd0, fail_cnt}, 32'd0);

        // clear wins over a simultaneous digit.
        enter3(3'd0, 3'd0, 3'd1);
        digit(3'd3);
        digit(3'd7);
        step(1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
        check("clear_idx", {30'd0, digit_idx}, 32'd0);
        check("clear_fail", {28'd0, fail_cnt}, 32'd1);
        check("clear_y", {31'd0, y}, 32'd0);
        enter3(3'd3, 3'd7, 3'd5);
        check("open_after_clear", {31'd0, y}, 32'd1);
        idle(10);

        // Reset in OPEN, in GOT2 and in LOCKOUT.
        enter3(3'd3, 3'd7, 3'd5);
        idle(3);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        check("rst_open_y", {31'd0, y}, 32'd0);
        digit(3'd3);
        digit(3'd7);
        step(1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        check("rst_got2_idx", {30'd0, digit_idx}, 32'd0);
        check("rst_got2_y", {31'd0, y}, 32'd0);
        for (int i = 0; i < MAX_FAIL; i++) enter3(3'd0, 3'd0, 3'd0);
        idle(5);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        check("rst_lock_alarm", {31'd0, alarm}, 32'd0);
        check("rst_lock_fail", {28'd0, fail_cnt}, 32'd0);

        // Reprogramming to 1,2,3 (ignored without the feature).
        enter3(3'd3, 3'd7, 3'd5);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        enter3(3'd1, 3'd2, 3'd3);
        idle(10);
        enter3(3'd3, 3'd7, 3'd5);
        check("old_code_y", {31'd0, y}, PROG_EN ? 32'd0 : 32'd1);
        check("old_code_fail", {28'd0, fail_cnt}, PROG_EN ? 32'd1 : 32'd0);
        idle(10);
        enter3(3'd1, 3'd2, 3'd3);
        check("new_code_y", {31'd0, y}, PROG_EN ? 32'd1 : 32'd0);
        idle(10);

        // Random traffic, biased toward the correct next digit.
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_xv  = ($urandom_range(0, 1) == 1);
            r_clr = ($urandom_range(0, 24) == 0);
            r_prg = ($urandom_range(0, 7) == 0);
            r_d   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 7) begin
                sh = (m_prog || m_en > 2) ? m_code : m_code << (3 * m_en);
                r_d = sh[8:6];
            end
            step(r_rst, r_xv, r_d, r_clr, r_prg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
